legv8_control_decoder: RTL and testbench

- Main control decoder for the single-issue LEGv8/ARM-style datapath.
- Decodes the 11-bit instruction opcode field (instr[31:21]) into datapath control signals: register-file, ALU, data-memory and branch control.
- One registered pipeline stage between the opcode input and the control outputs. The block sits between instruction fetch/decode and the datapath.

---
 rtl/legv8_control_decoder.sv | 131 +++++++++++++
 tb/tb_legv8_control_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_decoder.sv
// rtl/legv8_control_decoder.sv - LEGv8 main control decoder, one registered stage
// Optional illegal-opcode flags are built only when ILLEGAL_OPCODE_DETECT_EN is defined.
module legv8_control_decoder #(
    parameter int OPCODE_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                in_valid,
    output logic                out_valid,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                memtoreg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic                branch,
    output logic [1:0]          aluop
`ifdef ILLEGAL_OPCODE_DETECT_EN
    ,
    output logic                illegal,
    output logic                illegal_seen
`endif
);

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    localparam ctrl_t CTRL_NOP   = '{default: '0};
    localparam ctrl_t CTRL_LDUR  = '{reg2loc: 1'b0, alusrc: 1'b1, memtoreg: 1'b1, regwrite: 1'b1,
                                     memread: 1'b1, memwrite: 1'b0, branch: 1'b0, aluop: 2'b00};
    localparam ctrl_t CTRL_STUR  = '{reg2loc: 1'b1, alusrc: 1'b1, memtoreg: 1'b0, regwrite: 1'b0,
                                     memread: 1'b0, memwrite: 1'b1, branch: 1'b0, aluop: 2'b00};
    localparam ctrl_t CTRL_RTYPE = '{reg2loc: 1'b0, alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b1,
                                     memread: 1'b0, memwrite: 1'b0, branch: 1'b0, aluop: 2'b10};
    localparam ctrl_t CTRL_CBZ   = '{reg2loc: 1'b1, alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b0,
                                     memread: 1'b0, memwrite: 1'b0, branch: 1'b1, aluop: 2'b01};

    ctrl_t ctrl_d, ctrl_q;
    logic  valid_d, valid_q;
    logic  listed;
    ctrl_t decoded;

    // CBZ ignores the low three opcode bits; everything else needs an exact match.
    always_comb begin
        decoded = CTRL_NOP;
        listed  = 1'b1;
        if (opcode[10:3] == OP_CBZ) begin
            decoded = CTRL_CBZ;
        end else begin
            case (opcode)
                OP_LDUR: decoded = CTRL_LDUR;
                OP_STUR: decoded = CTRL_STUR;
                OP_ADD,
                OP_SUB,
                OP_AND,
                OP_ORR:  decoded = CTRL_RTYPE;
                default: listed  = 1'b0;
            endcase
        end
    end

    // A bubble clears every control so no write enable leaks through.
    always_comb begin
        valid_d = in_valid;
        ctrl_d  = in_valid ? decoded : CTRL_NOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = valid_q;
    assign reg2loc   = ctrl_q.reg2loc;
    assign alusrc    = ctrl_q.alusrc;
    assign memtoreg  = ctrl_q.memtoreg;
    assign regwrite  = ctrl_q.regwrite;
    assign memread   = ctrl_q.memread;
    assign memwrite  = ctrl_q.memwrite;
    assign branch    = ctrl_q.branch;
    assign aluop     = ctrl_q.aluop;

`ifdef ILLEGAL_OPCODE_DETECT_EN
    logic illegal_d, illegal_q;
    logic illegal_seen_d, illegal_seen_q;

    always_comb begin
        illegal_d      = in_valid && !listed;
        illegal_seen_d = illegal_seen_q || illegal_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q      <= 1'b0;
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_q      <= illegal_d;
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal      = illegal_q;
    assign illegal_seen = illegal_seen_q;
`else
    logic unused_listed;
    assign unused_listed = listed;
`endif

endmodule

// File: tb/tb_legv8_control_decoder.sv
// tb/tb_legv8_control_decoder.sv - scoreboard bench for legv8_control_decoder
module tb_legv8_control_decoder;

    logic        clk;
    logic        rst;
    logic [10:0] opcode;
    logic        in_valid;
    logic        out_valid, reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
    logic        illegal_o;
    logic        illegal_seen_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] vec;
        logic       ill;
        logic [10:0] op;
    } exp_t;

    exp_t exp_q[$];

    legv8_control_decoder #(.OPCODE_W(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .reg2loc   (reg2loc),
        .alusrc    (alusrc),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .memread   (memread),
        .memwrite  (memwrite),
        .branch    (branch),
        .aluop     (aluop)
`ifdef ILLEGAL_OPCODE_DETECT_EN
        ,
        .illegal      (illegal_o),
        .illegal_seen (illegal_seen_o)
`endif
    );

`ifndef ILLEGAL_OPCODE_DETECT_EN
    assign illegal_o      = 1'b0;
    assign illegal_seen_o = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] dut_vec();
        return {out_valid, reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop};
    endfunction

    // Hand-written decode table: {reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}
    function automatic logic [9:0] model(input logic [10:0] op, input logic v, output logic ill);
        logic [8:0] c;
        logic       hit;
        hit = 1'b1;
        casez (op)
            11'b11111000010: c = 9'b0_1_1_1_1_0_0_00;
            11'b11111000000: c = 9'b1_1_0_0_0_1_0_00;
            11'b10001011000: c = 9'b0_0_0_1_0_0_0_10;
            11'b11001011000: c = 9'b0_0_0_1_0_0_0_10;
            11'b10001010000: c = 9'b0_0_0_1_0_0_0_10;
            11'b10101010000: c = 9'b0_0_0_1_0_0_0_10;
            11'b10110100???: c = 9'b1_0_0_0_0_0_1_01;
            default: begin c = 9'b0; hit = 1'b0; end
        endcase
`ifdef ILLEGAL_OPCODE_DETECT_EN
        ill = v && !hit;
`else
        ill = 1'b0;
`endif
        return v ? {1'b1, c} : 10'b0;
    endfunction

    task automatic drive(input logic [10:0] op, input logic v);
        exp_t e;
        @(negedge clk);
        opcode   = op;
        in_valid = v;
        e.op     = op;
        e.vec    = model(op, v, e.ill);
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Monitor: each edge that follows an issued vector pops and compares one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now($sformatf("decode op=%b", e.op), {1'b0, dut_vec()}, {1'b0, e.vec});
`ifdef ILLEGAL_OPCODE_DETECT_EN
                check_now($sformatf("illegal op=%b", e.op), {10'b0, illegal_o}, {10'b0, e.ill});
`endif
                check_now("mem rd&wr exclusive", {10'b0, memread & memwrite}, 11'b0);
                check_now("regwr&memwr exclusive", {10'b0, regwrite & memwrite}, 11'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        check_now("scoreboard drained", {10'b0, exp_q.size() == 0}, 11'b1);
    endtask

    logic [10:0] table_ops [7];

    initial begin
        table_ops = '{11'b11111000010, 11'b11111000000, 11'b10001011000, 11'b11001011000,
                      11'b10001010000, 11'b10101010000, 11'b10110100000};
        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset outputs", {1'b0, dut_vec()}, 11'b0);
        check_now("reset illegal flags", {9'b0, illegal_o, illegal_seen_o}, 11'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (table_ops[i]) drive(table_ops[i], 1'b1);
        drive(11'b10110100111, 1'b1);
        drive(11'b10110100011, 1'b1);
        drive(11'b11111000011, 1'b1);
        drive(11'b10001011000, 1'b1);
        drive(11'b10001011000, 1'b0);
        drive(11'b11111000010, 1'b0);
        drain();
`ifdef ILLEGAL_OPCODE_DETECT_EN
        check_now("illegal_seen sticky", {10'b0, illegal_seen_o}, 11'b1);
`endif

        for (int i = 0; i < 2048; i++) drive(i[10:0], 1'b1);
        drain();

        drive(11'b11111000010, 1'b1);
        drain();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_now("async reset clears", {1'b0, dut_vec()}, 11'b0);
        check_now("async reset flags", {9'b0, illegal_o, illegal_seen_o}, 11'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(11'b11111000010, 1'b0);
        drive(11'b10001011000, 1'b0);
        drain();
        check_now("post reset flags", {9'b0, illegal_o, illegal_seen_o}, 11'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
